// File: rtl/snes_controller_multi_if.sv
// Bus bundle between the multi-pad SNES reader and its surroundings.
// The controller side (master) drives LATCH/PULSE to the pads and the
// decoded button vectors to the core; the slave side supplies ENABLE and
// the per-pad DATA lines.
// Optional feature macro: SNES_EDGE_EN adds PRESSED/RELEASED edge vectors.
interface snes_controller_multi_if #(
  parameter int N_CH      = 2,
  parameter int N_BUTTONS = 12
);
  logic                      ENABLE;
  logic [N_CH-1:0]           DATA;
  logic                      LATCH;
  logic                      PULSE;
  logic [N_CH*N_BUTTONS-1:0] BUTTONS;
  logic                      FRAME_VALID;
  logic                      BUSY;
`ifdef SNES_EDGE_EN
  logic [N_CH*N_BUTTONS-1:0] PRESSED;
  logic [N_CH*N_BUTTONS-1:0] RELEASED;
`endif

  modport master (
    input  ENABLE,
    input  DATA,
    output LATCH,
    output PULSE,
    output BUTTONS,
    output FRAME_VALID,
`ifdef SNES_EDGE_EN
    output PRESSED,
    output RELEASED,
`endif
    output BUSY
  );

  modport slave (
    output ENABLE,
    output DATA,
    input  LATCH,
    input  PULSE,
    input  BUTTONS,
    input  FRAME_VALID,
`ifdef SNES_EDGE_EN
    input  PRESSED,
    input  RELEASED,
`endif
    input  BUSY
  );
endinterface

// File: rtl/snes_controller_multi.sv
// N-channel SNES pad reader. One shared LATCH/PULSE pair drives every pad,
// each pad's DATA line is synchronised and sampled in the same cycle, and
// the decoded active-high button vectors update once per poll frame with a
// one-cycle FRAME_VALID strobe.
// Optional feature macro: SNES_EDGE_EN adds per-frame PRESSED/RELEASED
// vectors (new & ~old, ~new & old), valid only alongside FRAME_VALID.
module snes_controller_multi #(
  parameter int N_CH         = 2,
  parameter int N_BITS       = 16,
  parameter int N_BUTTONS    = 12,
  parameter int HALF_CYCLES  = 150,
  parameter int LATCH_CYCLES = 600,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  snes_controller_multi_if.master bus
);

  localparam int NB_TOT = N_CH * N_BUTTONS;
  localparam int CNT_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PH_MAX = (HALF_CYCLES > LATCH_CYCLES) ? HALF_CYCLES : LATCH_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_poll;
  logic [PH_W-1:0]     r_ph;
  logic [IDX_W-1:0]    r_idx;
  logic                r_latch;
  logic                r_pulse;
  logic                r_frame_valid;
  logic                r_busy;
  logic [NB_TOT-1:0]   r_buttons;
`ifdef SNES_EDGE_EN
  logic [NB_TOT-1:0]   r_pressed;
  logic [NB_TOT-1:0]   r_released;
`endif

  logic                w_poll_wrap;
  logic                w_start;
  logic                w_half_end;
  logic                w_latch_end;
  logic                w_sample;
  logic [NB_TOT-1:0]   w_new;

  assign w_poll_wrap = (r_poll == CNT_W'(POLL_CYCLES - 1));
  assign w_start     = (r_state == S_IDLE) && bus.ENABLE && w_poll_wrap;
  assign w_half_end  = (r_ph == PH_W'(HALF_CYCLES - 1));
  assign w_latch_end = (r_ph == PH_W'(LATCH_CYCLES - 1));
  // Pad bits are captured in the last cycle of each PULSE-low half period.
  assign w_sample    = (r_state == S_LOW) && w_half_end;

  // Free-running frame-rate counter; the wrap point coincides with LATCH rise.
  // Reset preloads the wrap value so polling starts on the first edge.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_poll <= CNT_W'(POLL_CYCLES - 1);
    end else if (w_poll_wrap) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic                 r_sync1;
      logic                 r_sync2;
      logic [N_BUTTONS-1:0] r_shift;

      // Two-flop synchroniser on the pad line, then capture of the kept bits;
      // bits at or beyond N_BUTTONS are clocked out by the pad but not stored.
      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_shift <= '0;
        end else begin
          r_sync1 <= bus.DATA[gi];
          r_sync2 <= r_sync1;
          if (w_sample) begin
            for (int b = 0; b < N_BUTTONS; b++) begin
              if (r_idx == IDX_W'(b)) begin
                r_shift[b] <= r_sync2;
              end
            end
          end
        end
      end

      // Pad data is active-low; present pressed buttons as ones.
      assign w_new[gi*N_BUTTONS +: N_BUTTONS] = ~r_shift;
    end
  endgenerate

  // Frame sequencer: LATCH pulse, N_BITS PULSE periods, then a one-cycle
  // DONE that publishes the new button vectors.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_ph          <= '0;
      r_idx         <= '0;
      r_latch       <= 1'b0;
      r_pulse       <= 1'b1;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_buttons     <= '0;
`ifdef SNES_EDGE_EN
      r_pressed     <= '0;
      r_released    <= '0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
`ifdef SNES_EDGE_EN
      r_pressed     <= '0;
      r_released    <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_LATCH;
            r_latch <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_ph    <= '0;
          end
        end
        S_LATCH: begin
          if (w_latch_end) begin
            r_state <= S_LOW;
            r_latch <= 1'b0;
            r_pulse <= 1'b0;
            r_ph    <= '0;
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        S_LOW: begin
          if (w_half_end) begin
            r_state <= S_HIGH;
            r_pulse <= 1'b1;
            r_ph    <= '0;
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        S_HIGH: begin
          if (w_half_end) begin
            r_ph <= '0;
            if (r_idx == IDX_W'(N_BITS - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_LOW;
              r_pulse <= 1'b0;
              r_idx   <= r_idx + IDX_W'(1);
            end
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_frame_valid <= 1'b1;
          r_buttons     <= w_new;
`ifdef SNES_EDGE_EN
          r_pressed     <= w_new & ~r_buttons;
          r_released    <= ~w_new & r_buttons;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.LATCH       = r_latch;
  assign bus.PULSE       = r_pulse;
  assign bus.BUTTONS     = r_buttons;
  assign bus.FRAME_VALID = r_frame_valid;
  assign bus.BUSY        = r_busy;
`ifdef SNES_EDGE_EN
  assign bus.PRESSED     = r_pressed;
  assign bus.RELEASED    = r_released;
`endif

endmodule

// File: tb/tb_snes_controller_multi.sv
// Directed bench for snes_controller_multi with two modelled pads.
// Timing reference: cyc counts clock edges since the most recent LATCH rise.
module tb_snes_controller_multi;

  logic CLOCK = 1'b0;
  logic RESET_N;

  snes_controller_multi_if #(.N_CH(2), .N_BUTTONS(12)) bus ();

  snes_controller_multi #(
    .N_CH(2), .N_BITS(16), .N_BUTTONS(12),
    .HALF_CYCLES(4), .LATCH_CYCLES(8), .POLL_CYCLES(400)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // Pad model: LATCH loads the pad, each PULSE rise advances to the next
  // bit; DATA is active-low, bits past the 12 buttons read released.
  logic [11:0] pad_btn [2];
  logic [1:0]  tie_high;
  logic [4:0]  pidx    = 5'd31;
  logic        pulse_d = 1'b1;

  always @(posedge CLOCK) begin
    pulse_d <= bus.PULSE;
    if (bus.LATCH) pidx <= 5'd0;
    else if (bus.PULSE && !pulse_d && pidx != 5'd31) pidx <= pidx + 5'd1;
  end

  function automatic logic pad_bit(input logic [11:0] btn, input logic th, input logic [4:0] idx);
    if (th || idx >= 5'd12) return 1'b1;
    return ~btn[idx[3:0]];
  endfunction

  assign bus.DATA = {pad_bit(pad_btn[1], tie_high[1], pidx),
                     pad_bit(pad_btn[0], tie_high[0], pidx)};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the given edge count (relative to LATCH rise), sampling #1 after the edge.
  task automatic adv(input int target);
    while (cyc < target) begin
      @(posedge CLOCK);
      #1;
      cyc++;
    end
  endtask

  // Confirm the following LATCH rise lands exactly on the poll period.
  task automatic next_frame(input string tag);
    adv(399);
    check({tag, "_pre_latch"}, 64'(bus.LATCH), 64'd0);
    adv(400);
    check({tag, "_latch_rise"}, 64'(bus.LATCH), 64'd1);
    cyc = 0;
  endtask

  int lows, falls, lat_hi, fv_hi;
  logic prevp;
  logic btn_moved;

  initial begin
    RESET_N    = 1'b0;
    bus.ENABLE = 1'b1;
    tie_high   = 2'b00;
    pad_btn[0] = 12'h809;   // B, Start, R
    pad_btn[1] = 12'h002;   // Y
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_latch", 64'(bus.LATCH), 64'd0);
    check("rst_pulse", 64'(bus.PULSE), 64'd1);
    check("rst_buttons", 64'(bus.BUTTONS), 64'd0);
    check("rst_fv", 64'(bus.FRAME_VALID), 64'd0);
    check("rst_busy", 64'(bus.BUSY), 64'd0);

    // 1: first frame starts on the first edge after reset release
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;
    cyc = 0;
    check("t1_latch_rise", 64'(bus.LATCH), 64'd1);
    check("t1_busy_rise", 64'(bus.BUSY), 64'd1);
    adv(7);
    check("t1_latch_c7", 64'(bus.LATCH), 64'd1);
    check("t1_pulse_c7", 64'(bus.PULSE), 64'd1);
    adv(8);
    check("t1_latch_c8", 64'(bus.LATCH), 64'd0);
    check("t1_pulse_c8", 64'(bus.PULSE), 64'd0);
    lows = 0; falls = 0; prevp = 1'b1; btn_moved = 1'b0;
    for (int c = 8; c <= 136; c++) begin
      adv(c);
      if (!bus.PULSE) lows++;
      if (!bus.PULSE && prevp) falls++;
      prevp = bus.PULSE;
      if (bus.BUTTONS !== 24'h0 || bus.FRAME_VALID !== 1'b0) btn_moved = 1'b1;
    end
    check("t1_pulse_low_cycles", 64'(lows), 64'd64);
    check("t1_pulse_count", 64'(falls), 64'd16);
    check("t1_no_midframe_update", 64'(btn_moved), 64'd0);
    check("t1_busy_c136", 64'(bus.BUSY), 64'd1);
    adv(137);
    check("t1_fv_c137", 64'(bus.FRAME_VALID), 64'd1);
    check("t1_busy_c137", 64'(bus.BUSY), 64'd0);
    check("t2_buttons_a", 64'(bus.BUTTONS), 64'h002809);
    adv(138);
    check("t1_fv_c138", 64'(bus.FRAME_VALID), 64'd0);
    check("t1_buttons_hold", 64'(bus.BUTTONS), 64'h002809);
    next_frame("t1");

    // 2: different pattern on both pads
    pad_btn[0] = 12'h500;   // A, L
    pad_btn[1] = 12'hFFF;   // everything
    adv(136);
    check("t2_buttons_hold_c136", 64'(bus.BUTTONS), 64'h002809);
    adv(137);
    check("t2_fv", 64'(bus.FRAME_VALID), 64'd1);
    check("t2_buttons_b", 64'(bus.BUTTONS), 64'hFFF500);
    next_frame("t2");

    // 3: unplugged pads read all released
    tie_high = 2'b11;
    adv(137);
    check("t3_fv", 64'(bus.FRAME_VALID), 64'd1);
    check("t3_buttons", 64'(bus.BUTTONS), 64'd0);
    next_frame("t3");

    // 4: ENABLE drops mid-frame, frame completes, polling pauses
    tie_high   = 2'b00;
    pad_btn[0] = 12'h809;
    pad_btn[1] = 12'h002;
    adv(50);
    bus.ENABLE = 1'b0;
    adv(137);
    check("t4_fv", 64'(bus.FRAME_VALID), 64'd1);
    check("t4_buttons", 64'(bus.BUTTONS), 64'h002809);
    lat_hi = 0; fv_hi = 0;
    for (int c = 138; c <= 850; c++) begin
      adv(c);
      if (bus.LATCH) lat_hi++;
      if (bus.FRAME_VALID) fv_hi++;
    end
    check("t4_no_latch_disabled", 64'(lat_hi), 64'd0);
    check("t4_no_fv_disabled", 64'(fv_hi), 64'd0);
    check("t4_busy_idle", 64'(bus.BUSY), 64'd0);
    bus.ENABLE = 1'b1;
    adv(1199);
    check("t4_wait_wrap", 64'(bus.LATCH), 64'd0);
    adv(1200);
    check("t4_latch_on_wrap", 64'(bus.LATCH), 64'd1);
    cyc = 0;
    adv(137);
    check("t4_resume_fv", 64'(bus.FRAME_VALID), 64'd1);
    next_frame("t4");

    // 5: reset during the 7th PULSE low
    pad_btn[0] = 12'h500;
    pad_btn[1] = 12'hFFF;
    adv(58);
    check("t5_in_pulse7", 64'(bus.PULSE), 64'd0);
    check("t5_hold_before_rst", 64'(bus.BUTTONS), 64'h002809);
    RESET_N = 1'b0;
    #1;
    check("t5_rst_latch", 64'(bus.LATCH), 64'd0);
    check("t5_rst_pulse", 64'(bus.PULSE), 64'd1);
    check("t5_rst_buttons", 64'(bus.BUTTONS), 64'd0);
    check("t5_rst_busy", 64'(bus.BUSY), 64'd0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;
    cyc = 0;
    check("t5_relatch", 64'(bus.LATCH), 64'd1);
    adv(137);
    check("t5_clean_fv", 64'(bus.FRAME_VALID), 64'd1);
    check("t5_clean_buttons", 64'(bus.BUTTONS), 64'hFFF500);
    next_frame("t5");

`ifdef SNES_EDGE_EN
    // 6: edge vectors around an A press/release on pad0
    pad_btn[0] = 12'h000;
    pad_btn[1] = 12'h000;
    adv(137);
    check("t6_rel_all", 64'(bus.RELEASED), 64'hFFF500);
    check("t6_prs_none", 64'(bus.PRESSED), 64'd0);
    adv(138);
    check("t6_rel_cleared", 64'(bus.RELEASED), 64'd0);
    next_frame("t6a");
    pad_btn[0] = 12'h100;
    adv(137);
    check("t6_prs_n", 64'(bus.PRESSED), 64'h000100);
    check("t6_rel_n", 64'(bus.RELEASED), 64'd0);
    adv(138);
    check("t6_prs_n_cleared", 64'(bus.PRESSED), 64'd0);
    next_frame("t6b");
    adv(137);
    check("t6_prs_n1", 64'(bus.PRESSED), 64'd0);
    check("t6_rel_n1", 64'(bus.RELEASED), 64'd0);
    next_frame("t6c");
    pad_btn[0] = 12'h000;
    adv(137);
    check("t6_prs_n2", 64'(bus.PRESSED), 64'd0);
    check("t6_rel_n2", 64'(bus.RELEASED), 64'h000100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
